div_unit_ctrl: RTL and testbench

//  Front-end controller for the 32-bit radix-4 SRT divider core div32; sits between issue/RS and the CDB.

---
 rtl/div_unit_ctrl_pkg.sv | 29 ++
 rtl/div_unit_ctrl_if.sv | 27 ++
 rtl/div_special_case.sv | 33 +++
 rtl/div_unit_ctrl.sv | 160 ++++++++++++++++
 tb/tb_div_unit_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_ctrl_pkg.sv
// Shared types and constants for the divider front-end controller.
package div_unit_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        DRAIN,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_want_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_ctrl_if.sv
// Issue-side request and CDB-side result handshake of the divider controller.
interface div_unit_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    // Issue/CDB side: sends requests, grants results.
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Controller side.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/div_special_case.sv
// Combinational detection of divide-by-zero and signed overflow, with RV32M results.
module div_special_case
    import div_unit_ctrl_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_special,
    output logic [31:0] q_spec,
    output logic [31:0] rem_spec
);

    // Only the signedness bit matters here; quotient/remainder selection is the caller's job.
    logic op_unused;
    assign op_unused = op[1];

    // Divide-by-zero takes priority over overflow.
    always_comb begin
        is_special = 1'b0;
        q_spec     = '0;
        rem_spec   = '0;
        if (b == '0) begin
            is_special = 1'b1;
            q_spec     = '1;
            rem_spec   = a;
        end else if (op_is_signed(op) && a == DIV_OVF_A && b == '1) begin
            is_special = 1'b1;
            q_spec     = DIV_OVF_A;
            rem_spec   = '0;
        end
    end

endmodule

// File: rtl/div_unit_ctrl.sv
// Front-end controller for the div32 core: corner cases, one-entry reuse cache, flush handling.
module div_unit_ctrl
    import div_unit_ctrl_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter bit USE_CACHE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    div_unit_ctrl_if.slave      bus,
    output logic                dv_in_en,
    output logic [31:0]         dv_a,
    output logic [31:0]         dv_b,
    output logic                dv_signed,
    input  logic                dv_idle,
    input  logic                dv_out_en,
    input  logic [31:0]         dv_q,
    input  logic [31:0]         dv_rem
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;
    logic             c_vld_q, c_vld_d;
    logic [31:0]      c_a_q, c_a_d;
    logic [31:0]      c_b_q, c_b_d;
    logic             c_s_q, c_s_d;
    logic [31:0]      c_quo_q, c_quo_d;
    logic [31:0]      c_rem_q, c_rem_d;

    logic             in_ready;
    logic             is_special;
    logic [31:0]      q_spec;
    logic [31:0]      rem_spec;
    logic             cache_hit;

    div_special_case u_special (
        .op         (bus.in_op),
        .a          (bus.in_a),
        .b          (bus.in_b),
        .is_special (is_special),
        .q_spec     (q_spec),
        .rem_spec   (rem_spec)
    );

    assign in_ready      = (state_q == IDLE) && !flush;
    assign cache_hit     = USE_CACHE && c_vld_q && (c_a_q == bus.in_a) && (c_b_q == bus.in_b)
                           && (c_s_q == op_is_signed(bus.in_op));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == RESP);
    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;

    assign dv_in_en      = (state_q == ISSUE) && dv_idle && !flush;
    assign dv_a          = a_q;
    assign dv_b          = b_q;
    assign dv_signed     = op_is_signed(op_q);

    // Next-state, result capture and cache update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        data_d  = data_q;
        c_vld_d = c_vld_q;
        c_a_d   = c_a_q;
        c_b_d   = c_b_q;
        c_s_d   = c_s_q;
        c_quo_d = c_quo_q;
        c_rem_d = c_rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    op_d  = bus.in_op;
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    tag_d = bus.in_tag;
                    if (is_special) begin
                        data_d  = op_want_rem(bus.in_op) ? rem_spec : q_spec;
                        state_d = RESP;
                    end else if (cache_hit) begin
                        data_d  = op_want_rem(bus.in_op) ? c_rem_q : c_quo_q;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (flush)        state_d = IDLE;
                else if (dv_idle) state_d = BUSY;
            end
            BUSY: begin
                // A result coinciding with flush is discarded just like one arriving in DRAIN.
                if (dv_out_en) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        data_d  = op_want_rem(op_q) ? dv_rem : dv_q;
                        c_vld_d = 1'b1;
                        c_a_d   = a_q;
                        c_b_d   = b_q;
                        c_s_d   = op_is_signed(op_q);
                        c_quo_d = dv_q;
                        c_rem_d = dv_rem;
                        state_d = RESP;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dv_out_en) state_d = IDLE;
            end
            RESP: begin
                if (flush || bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, result and cache registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            c_vld_q <= 1'b0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_s_q   <= 1'b0;
            c_quo_q <= '0;
            c_rem_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            c_vld_q <= c_vld_d;
            c_a_q   <= c_a_d;
            c_b_q   <= c_b_d;
            c_s_q   <= c_s_d;
            c_quo_q <= c_quo_d;
            c_rem_q <= c_rem_d;
        end
    end

endmodule

// File: tb/tb_div_unit_ctrl.sv
// Directed bench for div_unit_ctrl with a 20-cycle div32 stand-in.
module tb_div_unit_ctrl;
    import div_unit_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    div_unit_ctrl_if #(.TAG_W(4)) bus ();

    logic        dv_in_en;
    logic [31:0] dv_a;
    logic [31:0] dv_b;
    logic        dv_signed;
    logic        dv_idle;
    logic        dv_out_en;
    logic [31:0] dv_q;
    logic [31:0] dv_rem;

    div_unit_ctrl #(.TAG_W(4), .USE_CACHE(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .dv_in_en  (dv_in_en),
        .dv_a      (dv_a),
        .dv_b      (dv_b),
        .dv_signed (dv_signed),
        .dv_idle   (dv_idle),
        .dv_out_en (dv_out_en),
        .dv_q      (dv_q),
        .dv_rem    (dv_rem)
    );

    // Core stand-in: latches operands on launch, strobes the result 20 cycles later.
    // It ignores the controller reset so an abandoned op keeps the core busy.
    int          m_cnt = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_s = 1'b0;
    logic        m_out_en = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    assign dv_idle   = (m_cnt == 0);
    assign dv_out_en = m_out_en;
    assign dv_q      = m_q;
    assign dv_rem    = m_r;

    always @(posedge clk) begin
        m_out_en <= 1'b0;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_out_en <= 1'b1;
                if (m_s) begin
                    m_q <= $signed(m_a) / $signed(m_b);
                    m_r <= $signed(m_a) % $signed(m_b);
                end else begin
                    m_q <= m_a / m_b;
                    m_r <= m_a % m_b;
                end
            end
        end else if (dv_in_en) begin
            m_a   <= dv_a;
            m_b   <= dv_b;
            m_s   <= dv_signed;
            m_cnt <= 20;
        end
    end

    int launches = 0;
    always @(posedge clk) if (dv_in_en) launches <= launches + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready) begin ok = 1'b1; break; end
            step();
        end
        check({name, " in_ready"}, 32'(ok), 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag,
                          input logic [31:0] exp_data, input int exp_launch, input bit exp_fast);
        int  l0;
        int  lat;
        bit  ok;
        wait_ready(name);
        l0 = launches;
        send(op, a, b, tag);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin ok = 1'b1; break; end
            step();
            lat++;
        end
        check({name, " out_valid"}, 32'(ok), 32'd1);
        check({name, " data"}, bus.out_data, exp_data);
        check({name, " tag"}, 32'(bus.out_tag), 32'(tag));
        check({name, " launches"}, 32'(launches - l0), 32'(exp_launch));
        if (exp_fast) check({name, " latency1"}, 32'(lat), 32'd1);
        else          check({name, " latency>20"}, 32'(lat > 20), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bit bad;
        bit ok;
        int l0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst dv_in_en", 32'(dv_in_en), 32'd0);
        check("rst out_data", bus.out_data, 32'd0);
        check("rst out_tag", 32'(bus.out_tag), 32'd0);
        rst = 1'b0;
        step();
        check("idle in_ready", 32'(bus.in_ready), 32'd1);

        run_op("divu100/7", DIV_OP_DIVU, 32'd100, 32'd7, 4'd3, 32'd14, 1, 1'b0);
        run_op("remu100/7", DIV_OP_REMU, 32'd100, 32'd7, 4'd4, 32'd2, 0, 1'b1);
        run_op("div-7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd5, 32'hFFFF_FFFD, 1, 1'b0);
        run_op("rem-7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 4'd6, 32'hFFFF_FFFF, 0, 1'b1);
        run_op("div5/0", DIV_OP_DIV, 32'd5, 32'd0, 4'd7, 32'hFFFF_FFFF, 0, 1'b1);
        run_op("remu5/0", DIV_OP_REMU, 32'd5, 32'd0, 4'd8, 32'd5, 0, 1'b1);
        run_op("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'h8000_0000, 0, 1'b1);
        run_op("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 32'd0, 0, 1'b1);

        // Flush mid-division: drain the core result, no response, no cache fill.
        wait_ready("flush");
        send(DIV_OP_DIVU, 32'd1000, 32'd10, 4'd11);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dv_in_en) begin ok = 1'b1; break; end
            step();
        end
        check("flush launch", 32'(ok), 32'd1);
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        bad = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.out_valid || bus.in_ready || dv_a != 32'd1000 || dv_b != 32'd10) bad = 1'b1;
            if (dv_out_en) begin ok = 1'b1; break; end
            step();
        end
        check("drain out_en seen", 32'(ok), 32'd1);
        check("drain quiet", 32'(bad), 32'd0);
        step();
        check("drain done in_ready", 32'(bus.in_ready), 32'd1);
        check("drain done out_valid", 32'(bus.out_valid), 32'd0);
        run_op("divu1000/10", DIV_OP_DIVU, 32'd1000, 32'd10, 4'd12, 32'd100, 1, 1'b0);

        // Back-pressure in RESP: result held stable, no accept.
        wait_ready("hold");
        send(DIV_OP_DIV, 32'd5, 32'd0, 4'd9);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.out_valid || bus.in_ready || bus.out_data != 32'hFFFF_FFFF || bus.out_tag != 4'd9)
                bad = 1'b1;
            step();
        end
        check("hold stable", 32'(bad), 32'd0);
        check("hold data", bus.out_data, 32'hFFFF_FFFF);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("hold in_ready after", 32'(bus.in_ready), 32'd1);

        // Flush in RESP drops the result.
        send(DIV_OP_REMU, 32'd9, 32'd0, 4'd2);
        check("resp flush pre", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("resp flush out_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-BUSY abandons the core op; next issue waits for the core to idle.
        wait_ready("rstbusy");
        l0 = launches;
        send(DIV_OP_DIVU, 32'd77, 32'd7, 4'd1);
        repeat (4) step();
        check("rstbusy launched", 32'(launches - l0), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstbusy out_valid", 32'(bus.out_valid), 32'd0);
        check("rstbusy in_ready", 32'(bus.in_ready), 32'd1);
        run_op("divu50/5", DIV_OP_DIVU, 32'd50, 32'd5, 4'd2, 32'd10, 1, 1'b0);
        run_op("remu50/5", DIV_OP_REMU, 32'd50, 32'd5, 4'd3, 32'd0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
